pseudo_dram_slave: RTL and testbench
====================================

PSEUDO_DRAM_SLAVE -- requirements
Module: pseudo_dram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 64-bit DRAM entries.
REQ-002 SHALL have parameter RD_LAT, default 2, wait cycles between read-address accept and R_VALID (legal range 1..15).
REQ-003 SHALL have parameter WR_LAT, default 2, wait cycles between write-data accept and B_VALID (legal range 1..15).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-005 SHALL have ports: AR_VALID in 1; AR_ADDR in 17; AR_READY out 1.
REQ-006 SHALL have ports: R_VALID out 1; R_DATA out 64; R_RESP out 2; R_READY in 1.
REQ-007 SHALL have ports: AW_VALID in 1; AW_ADDR in 17; AW_READY out 1; W_VALID in 1; W_DATA in 64; W_READY out 1.
REQ-008 SHALL have ports: B_VALID out 1; B_RESP out 2; B_READY in 1.
REQ-009 SHALL have ports: ld_en in 1, ld_idx in 8, ld_data in 64 (bench preload port).

Function
REQ-010 SHALL use single clock clk; reset is synchronous and active-high on rst.
REQ-011 SHALL decode address as legal iff addr[16]=1, addr[15:11]=0 and addr[2:0]=0; entry index = addr[10:3].
REQ-012 SHALL implement FSM states S_IDLE, S_AR, S_RLAT, S_R, S_AW, S_W, S_WLAT, S_B, one transaction at a time.
REQ-013 S_IDLE SHALL go to S_AR if AR_VALID=1, else to S_AW if AW_VALID=1 (read wins simultaneous requests), else stay.
REQ-014 AR_READY SHALL be 1 only in S_AR; S_AR SHALL latch AR_ADDR and go to S_RLAT in the same cycle.
REQ-015 S_RLAT SHALL hold exactly RD_LAT cycles (down-counter loaded on entry), then go to S_R.
REQ-016 In S_R: R_VALID=1; R_DATA = mem[index], or 0 if illegal address; R_DATA and R_RESP held stable until R_READY=1, then go to S_IDLE.
REQ-017 R_RESP SHALL be 2'b00 for legal and 2'b10 for illegal address; R_DATA/R_RESP SHALL be 0 outside S_R.
REQ-018 AW_READY SHALL be 1 only in S_AW; S_AW SHALL latch AW_ADDR and go to S_W.
REQ-019 W_READY SHALL be 1 only in S_W; on W_VALID=1 SHALL latch W_DATA and go to S_WLAT, else stay.
REQ-020 S_WLAT SHALL hold exactly WR_LAT cycles; on its last cycle SHALL write latched data to mem[index] if address legal, then go to S_B.
REQ-021 In S_B: B_VALID=1, B_RESP 2'b00 legal / 2'b10 illegal, held until B_READY=1, then S_IDLE; B_RESP=0 outside S_B.
REQ-022 Read data SHALL reflect every write committed before entry to S_R (no stale data).
REQ-023 ld_en=1 SHALL write ld_data to mem[ld_idx] in any state; if it collides with an S_WLAT commit to the same index, the AXI commit SHALL win.
REQ-024 Input changes while a channel is not in its accept state SHALL be ignored; no transaction SHALL be lost or duplicated.

Reset
REQ-025 On rst=1 at a clock edge: FSM to S_IDLE, counters and latched address/data to 0, all READY/VALID/RESP/R_DATA outputs 0.
REQ-026 Reset mid-transaction SHALL abort it with no memory write; memory contents SHALL NOT be cleared by reset.

Structure
REQ-027 State enum, response codes (OKAY=2'b00, SLVERR=2'b10) and DRAM base/decode constants SHALL live in the shared package used by the bridge.
REQ-028 SHALL contain one sub-module, dram_latency_cnt (loadable 4-bit down-counter with done flag), instantiated for both read and write waits.
REQ-029 Memory SHALL be a register array DEPTH x 64, no external SRAM macro.

Verification
REQ-030 Preload idx 5 = 64'hDEAD_BEEF_0123_4567; read AR_ADDR=17'h10028 -> R_VALID exactly RD_LAT+1 cycles after AR handshake, R_DATA=preload, R_RESP=00.
REQ-031 Write AW_ADDR=17'h107F8, W_DATA=64'h1 -> B_RESP=00 WR_LAT+1 cycles after W handshake; subsequent read of idx 255 returns 64'h1.
REQ-032 AR_VALID and AW_VALID both raised same cycle -> read completes first, then write; B_VALID follows.
REQ-033 Read AR_ADDR=17'h00028 (bit16=0) -> R_RESP=10, R_DATA=0; write to 17'h10029 -> B_RESP=10, memory unchanged.
REQ-034 Hold R_READY=0 for 5 cycles in S_R -> R_VALID/R_DATA stable all 5 cycles, single beat on R_READY=1.
REQ-035 Assert rst during S_WLAT -> outputs 0 next cycle, target entry keeps old value, next read returns old value.

Source files
------------

// File: rtl/pseudo_dram_slave_pkg.sv
// rtl/pseudo_dram_slave_pkg.sv - shared types, response codes and address decode for the pseudo DRAM slave
package pseudo_dram_slave_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RLAT,
    S_R,
    S_AW,
    S_W,
    S_WLAT,
    S_B
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 8;

  // DRAM window: bit 16 selects it, bits 15:11 must be clear, 8-byte aligned.
  localparam logic       DRAM_BASE_BIT = 1'b1;
  localparam logic [4:0] DRAM_HOLE     = 5'd0;
  localparam logic [2:0] DRAM_ALIGN    = 3'd0;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return (addr[16] == DRAM_BASE_BIT) && (addr[15:11] == DRAM_HOLE) &&
           (addr[2:0] == DRAM_ALIGN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[10:3];
  endfunction

endpackage

// File: rtl/dram_latency_cnt.sv
// rtl/dram_latency_cnt.sv - loadable 4-bit down-counter with done flag for access wait states
module dram_latency_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/pseudo_dram_slave.sv
// rtl/pseudo_dram_slave.sv - single-outstanding AXI-like DRAM model with fixed read/write latency
module pseudo_dram_slave
  import pseudo_dram_slave_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY,
  input  logic        ld_en,
  input  logic [7:0]  ld_idx,
  input  logic [63:0] ld_data
);

  // Counter is loaded with LAT-1 so the wait state lasts exactly LAT cycles.
  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             legal;
  logic [IDX_W-1:0] idx;
  logic             rd_load, wr_load, rd_done, wr_done;
  logic             latch_ar, latch_aw, latch_w, latch_r, commit;

  assign legal = addr_legal(addr_q);
  assign idx   = addr_index(addr_q);

  dram_latency_cnt u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_val (RD_LOAD),
    .done     (rd_done)
  );

  dram_latency_cnt u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_load),
    .load_val (WR_LOAD),
    .done     (wr_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, handshake outputs and datapath strobes.
  always_comb begin
    state_d  = state_q;
    AR_READY = 1'b0;
    R_VALID  = 1'b0;
    R_DATA   = '0;
    R_RESP   = '0;
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    B_VALID  = 1'b0;
    B_RESP   = '0;
    rd_load  = 1'b0;
    wr_load  = 1'b0;
    latch_ar = 1'b0;
    latch_aw = 1'b0;
    latch_w  = 1'b0;
    latch_r  = 1'b0;
    commit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (AR_VALID)      state_d = S_AR;
        else if (AW_VALID) state_d = S_AW;
      end
      S_AR: begin
        AR_READY = 1'b1;
        latch_ar = 1'b1;
        rd_load  = 1'b1;
        state_d  = S_RLAT;
      end
      S_RLAT: begin
        if (rd_done) begin
          latch_r = 1'b1;
          state_d = S_R;
        end
      end
      S_R: begin
        R_VALID = 1'b1;
        R_DATA  = rdata_q;
        R_RESP  = legal ? RESP_OKAY : RESP_SLVERR;
        if (R_READY) state_d = S_IDLE;
      end
      S_AW: begin
        AW_READY = 1'b1;
        latch_aw = 1'b1;
        state_d  = S_W;
      end
      S_W: begin
        W_READY = 1'b1;
        if (W_VALID) begin
          latch_w = 1'b1;
          wr_load = 1'b1;
          state_d = S_WLAT;
        end
      end
      S_WLAT: begin
        if (wr_done) begin
          commit  = legal;
          state_d = S_B;
        end
      end
      S_B: begin
        B_VALID = 1'b1;
        B_RESP  = legal ? RESP_OKAY : RESP_SLVERR;
        if (B_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latched address, write data and read data snapshot taken on entry to S_R.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (latch_ar)      addr_q <= AR_ADDR;
      else if (latch_aw) addr_q <= AW_ADDR;
      if (latch_w) wdata_q <= W_DATA;
      if (latch_r) rdata_q <= legal ? mem[idx] : '0;
    end
  end

  // Memory array: preload port first so a same-cycle bus commit overrides it.
  always_ff @(posedge clk) begin
    if (ld_en)          mem[ld_idx] <= ld_data;
    if (commit && !rst) mem[idx]    <= wdata_q;
  end

endmodule

// File: tb/tb_pseudo_dram_slave.sv
// tb/tb_pseudo_dram_slave.sv - scoreboard bench for pseudo_dram_slave
module tb_pseudo_dram_slave;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 3;
  localparam int BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        AR_VALID, AR_READY;
  logic [16:0] AR_ADDR;
  logic        R_VALID, R_READY;
  logic [63:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        AW_VALID, AW_READY;
  logic [16:0] AW_ADDR;
  logic        W_VALID, W_READY;
  logic [63:0] W_DATA;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [63:0] ld_data;

  pseudo_dram_slave #(.DEPTH(256), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst(rst),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] model [256];
  logic [65:0] rd_q [$];
  logic [1:0]  wr_q [$];
  time         r_done_time, b_time;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic legal_addr(input logic [16:0] a);
    return a[16] && (a[15:11] == 5'd0) && (a[2:0] == 3'd0);
  endfunction

  task automatic preload(input logic [7:0] idx, input logic [63:0] data);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    model[idx] = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run_read(input logic [16:0] addr, input int hold);
    int n;
    logic [65:0] exp;
    logic [63:0] d0;
    if (legal_addr(addr)) rd_q.push_back({2'b00, model[addr[10:3]]});
    else                  rd_q.push_back({2'b10, 64'h0});
    @(posedge clk); #1;
    AR_VALID = 1'b1; AR_ADDR = addr;
    n = 0;
    @(negedge clk);
    while (!AR_READY && n < BUDGET) begin @(negedge clk); n++; end
    if (!AR_READY) begin check("ar_timeout", 64'd0, 64'd1); AR_VALID = 1'b0; return; end
    @(posedge clk); #1;
    AR_VALID = 1'b0; AR_ADDR = 17'($urandom);
    @(negedge clk);
    n = 1;
    while (!R_VALID && n < BUDGET) begin @(negedge clk); n++; end
    check("rd_latency", 64'(n), 64'(RD_LAT + 1));
    if (!R_VALID) return;
    exp = rd_q.pop_front();
    d0 = R_DATA;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("r_hold_valid", {63'd0, R_VALID}, 64'd1);
      check("r_hold_data", R_DATA, d0);
    end
    @(posedge clk); #1;
    R_READY = 1'b1;
    @(negedge clk);
    check("r_data", R_DATA, exp[63:0]);
    check("r_resp", {62'd0, R_RESP}, {62'd0, exp[65:64]});
    @(posedge clk); #1;
    R_READY = 1'b0;
    r_done_time = $time;
    @(negedge clk);
    check("r_single_beat", {63'd0, R_VALID}, 64'd0);
  endtask

  task automatic run_write(input logic [16:0] addr, input logic [63:0] data);
    int n;
    logic [1:0] exp;
    if (legal_addr(addr)) begin
      wr_q.push_back(2'b00);
      model[addr[10:3]] = data;
    end else begin
      wr_q.push_back(2'b10);
    end
    @(posedge clk); #1;
    AW_VALID = 1'b1; AW_ADDR = addr;
    n = 0;
    @(negedge clk);
    while (!AW_READY && n < BUDGET) begin @(negedge clk); n++; end
    if (!AW_READY) begin check("aw_timeout", 64'd0, 64'd1); AW_VALID = 1'b0; return; end
    @(posedge clk); #1;
    AW_VALID = 1'b0; AW_ADDR = 17'($urandom);
    W_VALID = 1'b1; W_DATA = data;
    n = 0;
    @(negedge clk);
    while (!W_READY && n < BUDGET) begin @(negedge clk); n++; end
    if (!W_READY) begin check("w_timeout", 64'd0, 64'd1); W_VALID = 1'b0; return; end
    @(posedge clk); #1;
    W_VALID = 1'b0; W_DATA = {$urandom, $urandom};
    @(negedge clk);
    n = 1;
    while (!B_VALID && n < BUDGET) begin @(negedge clk); n++; end
    check("wr_latency", 64'(n), 64'(WR_LAT + 1));
    if (!B_VALID) return;
    b_time = $time;
    exp = wr_q.pop_front();
    check("b_resp", {62'd0, B_RESP}, {62'd0, exp});
    @(posedge clk); #1;
    B_READY = 1'b1;
    @(posedge clk); #1;
    B_READY = 1'b0;
    @(negedge clk);
    check("b_single_beat", {63'd0, B_VALID}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    AR_VALID = 0; AR_ADDR = 0; R_READY = 0;
    AW_VALID = 0; AW_ADDR = 0; W_VALID = 0; W_DATA = 0; B_READY = 0;
    ld_en = 0; ld_idx = 0; ld_data = 0;
    for (int i = 0; i < 256; i++) model[i] = 64'h0;
    for (int i = 0; i < 256; i++) preload(8'(i), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ar_ready", {63'd0, AR_READY}, 64'd0);
    check("rst_r_valid",  {63'd0, R_VALID},  64'd0);
    check("rst_r_data",   R_DATA,            64'd0);
    check("rst_aw_ready", {63'd0, AW_READY}, 64'd0);
    check("rst_b_valid",  {63'd0, B_VALID},  64'd0);
    check("rst_b_resp",   {62'd0, B_RESP},   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    preload(8'd5, 64'hDEAD_BEEF_0123_4567);
    run_read(17'h10028, 0);

    run_write(17'h107F8, 64'h1);
    run_read(17'h107F8, 0);

    fork
      run_read(17'h10028, 0);
      run_write(17'h10030, 64'hA5A5_5A5A_F00D_CAFE);
    join
    check("read_before_write", {63'd0, (r_done_time < b_time)}, 64'd1);
    run_read(17'h10030, 0);

    run_read(17'h00028, 0);
    run_write(17'h10029, 64'hFFFF_FFFF_FFFF_FFFF);
    run_read(17'h10028, 0);

    preload(8'd9, 64'h1234_5678_9ABC_DEF0);
    run_read(17'h10048, 5);

    // Reset during the write wait state: no commit, outputs cleared.
    preload(8'd7, 64'h0BAD_F00D_0000_0007);
    @(posedge clk); #1;
    AW_VALID = 1'b1; AW_ADDR = 17'h10038;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_aw_ready", {63'd0, AW_READY}, 64'd1);
    @(posedge clk); #1;
    AW_VALID = 1'b0; W_VALID = 1'b1; W_DATA = 64'h7777_7777_7777_7777;
    @(negedge clk);
    check("abort_w_ready", {63'd0, W_READY}, 64'd1);
    @(posedge clk); #1;
    W_VALID = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_b_valid",  {63'd0, B_VALID},  64'd0);
    check("abort_w_ready0", {63'd0, W_READY},  64'd0);
    check("abort_r_valid",  {63'd0, R_VALID},  64'd0);
    repeat (WR_LAT + 2) @(negedge clk);
    check("abort_no_b", {63'd0, B_VALID}, 64'd0);
    run_read(17'h10038, 0);

    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
